// File: rtl/decode_execute_if.sv
// Decode-to-execute bundle: decode-stage control/operands (xxxD) in, execute-stage copies (xxxE) out.
// Handshake: none; en/flush are plain per-edge controls and every xxxE is valid one edge after its xxxD.
interface decode_execute_if #(
  parameter int XLEN      = 32,
  parameter int REG_AW    = 5,
  parameter int ALUCTRL_W = 3
);
  logic                 en;
  logic                 flush;
  logic                 ValidD;
  logic                 RegWriteD, MemWriteD, ResultSrcD, ALUSrcD, BranchD;
  logic [ALUCTRL_W-1:0] ALUControlD;
  logic [XLEN-1:0]      RD1D, RD2D, PCD, PCPlus4D, ImmExtD;
  logic [REG_AW-1:0]    Rs1D, Rs2D, RdD;

  logic                 ValidE;
  logic                 RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE;
  logic [ALUCTRL_W-1:0] ALUControlE;
  logic [XLEN-1:0]      RD1E, RD2E, PCE, PCPlus4E, ImmExtE;
  logic [REG_AW-1:0]    Rs1E, Rs2E, RdE;

  modport master (
    output en, flush, ValidD, RegWriteD, MemWriteD, ResultSrcD, ALUSrcD, BranchD,
           ALUControlD, RD1D, RD2D, PCD, PCPlus4D, ImmExtD, Rs1D, Rs2D, RdD,
    input  ValidE, RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE,
           ALUControlE, RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE
  );

  modport slave (
    input  en, flush, ValidD, RegWriteD, MemWriteD, ResultSrcD, ALUSrcD, BranchD,
           ALUControlD, RD1D, RD2D, PCD, PCPlus4D, ImmExtD, Rs1D, Rs2D, RdD,
    output ValidE, RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE,
           ALUControlE, RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE
  );
endinterface

// File: rtl/decode_execute_register.sv
// ID/EX pipeline register with stall (en=0) and flush (bubble). Flush beats stall.
// Optional DEX_BUBBLE_CNT_EN adds a saturating 16-bit bubble counter output BubbleCntE.
module decode_execute_register #(
  parameter int XLEN      = 32,
  parameter int REG_AW    = 5,
  parameter int ALUCTRL_W = 3
) (
  input  logic        clk,
  input  logic        rst,
`ifdef DEX_BUBBLE_CNT_EN
  output logic [15:0] BubbleCntE,
`endif
  decode_execute_if.slave bus
);
  logic                 valid_q, regwrite_q, memwrite_q, resultsrc_q, alusrc_q, branch_q;
  logic                 valid_d, regwrite_d, memwrite_d, resultsrc_d, alusrc_d, branch_d;
  logic [ALUCTRL_W-1:0] aluctrl_q, aluctrl_d;
  logic [XLEN-1:0]      rd1_q, rd2_q, pc_q, pcplus4_q, imm_q;
  logic [XLEN-1:0]      rd1_d, rd2_d, pc_d, pcplus4_d, imm_d;
  logic [REG_AW-1:0]    rs1_q, rs2_q, rd_q, rs1_d, rs2_d, rd_d;

  always_comb begin
    valid_d     = valid_q;
    regwrite_d  = regwrite_q;
    memwrite_d  = memwrite_q;
    resultsrc_d = resultsrc_q;
    alusrc_d    = alusrc_q;
    branch_d    = branch_q;
    aluctrl_d   = aluctrl_q;
    rd1_d       = rd1_q;
    rd2_d       = rd2_q;
    pc_d        = pc_q;
    pcplus4_d   = pcplus4_q;
    imm_d       = imm_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_d        = rd_q;
    if (bus.flush) begin
      valid_d     = 1'b0;
      regwrite_d  = 1'b0;
      memwrite_d  = 1'b0;
      resultsrc_d = 1'b0;
      alusrc_d    = 1'b0;
      branch_d    = 1'b0;
      aluctrl_d   = '0;
      rd1_d       = '0;
      rd2_d       = '0;
      pc_d        = '0;
      pcplus4_d   = '0;
      imm_d       = '0;
      rs1_d       = '0;
      rs2_d       = '0;
      rd_d        = '0;
    end else if (bus.en) begin
      // Side-effecting bits are gated so a non-valid slot can never write or branch.
      valid_d     = bus.ValidD;
      regwrite_d  = bus.RegWriteD & bus.ValidD;
      memwrite_d  = bus.MemWriteD & bus.ValidD;
      branch_d    = bus.BranchD & bus.ValidD;
      resultsrc_d = bus.ResultSrcD;
      alusrc_d    = bus.ALUSrcD;
      aluctrl_d   = bus.ALUControlD;
      rd1_d       = bus.RD1D;
      rd2_d       = bus.RD2D;
      pc_d        = bus.PCD;
      pcplus4_d   = bus.PCPlus4D;
      imm_d       = bus.ImmExtD;
      rs1_d       = bus.Rs1D;
      rs2_d       = bus.Rs2D;
      rd_d        = bus.RdD;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= 1'b0;
      regwrite_q  <= 1'b0;
      memwrite_q  <= 1'b0;
      resultsrc_q <= 1'b0;
      alusrc_q    <= 1'b0;
      branch_q    <= 1'b0;
      aluctrl_q   <= '0;
      rd1_q       <= '0;
      rd2_q       <= '0;
      pc_q        <= '0;
      pcplus4_q   <= '0;
      imm_q       <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
    end else begin
      valid_q     <= valid_d;
      regwrite_q  <= regwrite_d;
      memwrite_q  <= memwrite_d;
      resultsrc_q <= resultsrc_d;
      alusrc_q    <= alusrc_d;
      branch_q    <= branch_d;
      aluctrl_q   <= aluctrl_d;
      rd1_q       <= rd1_d;
      rd2_q       <= rd2_d;
      pc_q        <= pc_d;
      pcplus4_q   <= pcplus4_d;
      imm_q       <= imm_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
    end
  end

  assign bus.ValidE      = valid_q;
  assign bus.RegWriteE   = regwrite_q;
  assign bus.MemWriteE   = memwrite_q;
  assign bus.ResultSrcE  = resultsrc_q;
  assign bus.ALUSrcE     = alusrc_q;
  assign bus.BranchE     = branch_q;
  assign bus.ALUControlE = aluctrl_q;
  assign bus.RD1E        = rd1_q;
  assign bus.RD2E        = rd2_q;
  assign bus.PCE         = pc_q;
  assign bus.PCPlus4E    = pcplus4_q;
  assign bus.ImmExtE     = imm_q;
  assign bus.Rs1E        = rs1_q;
  assign bus.Rs2E        = rs2_q;
  assign bus.RdE         = rd_q;

`ifdef DEX_BUBBLE_CNT_EN
  logic [15:0] bubble_cnt_q, bubble_cnt_d;
  logic        bubble_edge;

  // A bubble enters EX either by flush or by loading a non-valid decode slot.
  assign bubble_edge = bus.flush | (bus.en & ~bus.ValidD);

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (bubble_edge && bubble_cnt_q != 16'hFFFF) bubble_cnt_d = bubble_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) bubble_cnt_q <= '0;
    else     bubble_cnt_q <= bubble_cnt_d;
  end

  assign BubbleCntE = bubble_cnt_q;
`endif
endmodule

// File: doc/decode_execute_register.md
Name: decode_execute_register

Overview:
- Decode-to-execute (ID/EX) pipeline register of the 5-stage RISC-V core.
- Captures the control word from the main decoder: RegWrite, MemWrite, ResultSrc, ALUSrc, Branch, plus ALU control from the ALU decoder.
- Also captures the decode-stage datapath operands, and presents all of them to the execute stage one cycle later.
- Adds stall (hold) and flush (bubble insertion) so later hazard logic can drive it; with en=1 and flush=0 it acts as a plain register.

Parameters:
- XLEN, 32, datapath width of register operands, PC and immediate.
- REG_AW, 5, register-file address width.
- ALUCTRL_W, 3, width of the ALU control field.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  1 = load new decode values; 0 = hold (stall).
- flush  input  1  1 = load a bubble (all-zero control word).
- ValidD  input  1  decode stage holds a real instruction.
- RegWriteD, MemWriteD, ResultSrcD, ALUSrcD, BranchD  input  1 each  main-decoder control bits.
- ALUControlD  input  ALUCTRL_W  ALU operation select.
- RD1D, RD2D  input  XLEN  register-file read data.
- PCD, PCPlus4D, ImmExtD  input  XLEN  PC, PC+4, sign-extended immediate.
- Rs1D, Rs2D, RdD  input  REG_AW  source and destination register addresses.
- ValidE  output  1  execute stage holds a real instruction.
- RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE  output  1 each  registered control bits.
- ALUControlE  output  ALUCTRL_W  registered ALU control.
- RD1E, RD2E, PCE, PCPlus4E, ImmExtE  output  XLEN  registered datapath values.
- Rs1E, Rs2E, RdE  output  REG_AW  registered register addresses.
- BubbleCntE  output  16  only present with DEX_BUBBLE_CNT_EN.

Behaviour:
- Reset:
  - rst=1 asynchronously clears every output to 0, independent of clk.
  - State after reset is a bubble: ValidE=0, no writes, no branch.
- Each rising edge with rst=0 follows this priority:
  1. flush=1: all outputs load 0 (control, data, addresses, ValidE). flush overrides en=0, so a stalled stage can still be squashed.
  2. flush=0, en=0: all outputs hold their current value.
  3. flush=0, en=1: every xxxE output loads its xxxD input; ValidE loads ValidD.
- Latency: exactly one cycle from D inputs to E outputs. No combinational path from any input to any output.
- Bubble gating on load:
  - If ValidD=0, RegWriteE, MemWriteE and BranchE load 0 regardless of their D inputs.
  - All other fields load normally.
  - A non-valid slot therefore never has architectural side effects.
- No internal state other than the output registers (and the optional counter). No state machine.
- Reset mid-stall or mid-flush: reset wins immediately. On the first edge after rst falls, the normal priority applies.
- X-safety: with en=0, D inputs may be X without affecting outputs.

Optional Feature:
- Macro: DEX_BUBBLE_CNT_EN.
- Defined:
  - Adds output BubbleCntE[15:0], reset asynchronously to 0.
  - Increments by 1 on every rising edge where rst=0 and flush=1.
  - Also increments on a load edge (en=1, flush=0) with ValidD=0.
  - Saturates at 16'hFFFF; never wraps.
  - Holds on stall edges.
- Not defined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset check: assert rst mid-cycle with outputs loaded (RD1E=32'hDEADBEEF) -> all outputs 0 before the next clk edge, ValidE=0.
- Pass-through: en=1, flush=0, ValidD=1, decode lw (RegWriteD=1, ResultSrcD=1, ALUSrcD=1, ImmExtD=32'h0000_0010, RdD=5'd7) -> identical values on E outputs exactly one edge later, ValidE=1.
- Stall: load sw (MemWriteD=1, RD2D=32'h1234_5678), then en=0 for 3 cycles while D inputs change to random values -> E outputs stay at the sw values for all 3 cycles.
- Flush over stall: en=0, flush=1 with beq loaded (BranchE=1) -> next edge: all E outputs 0, ValidE=0.
- Invalid slot: en=1, ValidD=0, RegWriteD=1, MemWriteD=1, BranchD=1, RdD=5'd3 -> RegWriteE=MemWriteE=BranchE=0, RdE=5'd3, ValidE=0.
- Counter (macro defined): 5 flush edges plus 2 invalid loads -> BubbleCntE=7. Force the counter to 16'hFFFF and flush again -> stays 16'hFFFF.
